sb_tx_msg_arbiter: RTL and testbench

- Shares the single sideband transmit path (64-bit packet serializer interface) among N link-training requesters (SBINIT, MBINIT, MBTRAIN, LTSM).
- Round-robin arbitration picks one pending message.
- Builds and issues the 64-bit header packet, then the optional 64-bit data packet.
- Acknowledges the winning requester. The header layout matches the receive-side decoder: MsgCode at [21:14], MsgSubCode at [39:32].

---
 rtl/sb_tx_msg_arbiter_if.sv | 31 +++
 rtl/sb_tx_msg_arbiter.sv | 138 +++++++++++++
 tb/tb_sb_tx_msg_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/sb_tx_msg_arbiter_if.sv
// Bus between the link-training requesters / sideband serializer and the
// transmit message arbiter.
interface sb_tx_msg_arbiter_if #(
  parameter int N_REQ = 4
) ();
  logic [N_REQ-1:0]      i_req;
  logic [8*N_REQ-1:0]    i_msgcode;
  logic [8*N_REQ-1:0]    i_msgsubcode;
  logic [16*N_REQ-1:0]   i_msginfo;
  logic [N_REQ-1:0]      i_has_data;
  logic [64*N_REQ-1:0]   i_data;
  logic                  i_tx_ready;
  logic                  o_tx_valid;
  logic [63:0]           o_tx_packet;
  logic                  o_tx_is_data;
  logic [N_REQ-1:0]      o_ack;
  logic                  o_busy;
  logic [1:0]            dbg_state;

  // A packet moves on every clock edge where o_tx_valid && i_tx_ready; while
  // valid is high and ready is low the packet and is_data stay unchanged.
  modport master (
    output i_req, i_msgcode, i_msgsubcode, i_msginfo, i_has_data, i_data, i_tx_ready,
    input  o_tx_valid, o_tx_packet, o_tx_is_data, o_ack, o_busy, dbg_state
  );

  modport slave (
    input  i_req, i_msgcode, i_msgsubcode, i_msginfo, i_has_data, i_data, i_tx_ready,
    output o_tx_valid, o_tx_packet, o_tx_is_data, o_ack, o_busy, dbg_state
  );
endinterface

// File: rtl/sb_tx_msg_arbiter.sv
// Round-robin arbiter sharing the sideband TX serializer among link-training
// requesters; sends a header packet, then an optional data packet, then acks.
module sb_tx_msg_arbiter #(
  parameter int N_REQ = 4,
  parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  sb_tx_msg_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, DATA = 2'd2, DONE = 2'd3} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, g_q, sel_idx, scan_idx;
  logic               sel_found;
  logic               hd_q;
  logic [63:0]        data_q;
  logic [7:0]         sel_code, sel_sub;
  logic [15:0]        sel_info;
  logic               sel_hd;
  logic [63:0]        sel_data;

  logic               valid_q, valid_d, is_data_q, is_data_d, busy_q, busy_d;
  logic [63:0]        pkt_q, pkt_d;
  logic [N_REQ-1:0]   ack_q, ack_d;

  function automatic logic [63:0] build_hdr(input logic [7:0] code, input logic [7:0] sub,
                                            input logic [15:0] info, input logic hd);
    logic [63:0] h;
    h        = '0;
    h[4:0]   = hd ? 5'b11011 : 5'b10010;
    h[21:14] = code;
    h[39:32] = sub;
    h[55:40] = info;
    h[63]    = ^h[62:0];
    return h;
  endfunction

  // Search from rr_ptr upward; the last winner sits just below rr_ptr.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_idx = PTR_W'((int'(rr_ptr_q) + i) % N_REQ);
      if (!sel_found && bus.i_req[scan_idx]) begin
        sel_found = 1'b1;
        sel_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    sel_code = '0;
    sel_sub  = '0;
    sel_info = '0;
    sel_hd   = 1'b0;
    sel_data = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (sel_idx == PTR_W'(j)) begin
        sel_code = bus.i_msgcode[8*j +: 8];
        sel_sub  = bus.i_msgsubcode[8*j +: 8];
        sel_info = bus.i_msginfo[16*j +: 16];
        sel_hd   = bus.i_has_data[j];
        sel_data = bus.i_data[64*j +: 64];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      g_q      <= '0;
      hd_q     <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && sel_found) begin
        g_q    <= sel_idx;
        hd_q   <= sel_hd;
        data_q <= sel_data;
      end
      if (state_q == DONE)
        rr_ptr_q <= (g_q == PTR_W'(N_REQ - 1)) ? '0 : g_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sel_found) state_d = HDR;
      HDR:     if (bus.i_tx_ready) state_d = hd_q ? DATA : DONE;
      DATA:    if (bus.i_tx_ready) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so they can be registered
  // without adding a cycle of latency.
  always_comb begin
    valid_d   = (state_d == HDR) || (state_d == DATA);
    is_data_d = (state_d == DATA);
    busy_d    = (state_d != IDLE);
    ack_d     = '0;
    if (state_d == DONE)
      ack_d = {{(N_REQ-1){1'b0}}, 1'b1} << g_q;
    pkt_d = pkt_q;
    if (state_q == IDLE && state_d == HDR)
      pkt_d = build_hdr(sel_code, sel_sub, sel_info, sel_hd);
    else if (state_q == HDR && state_d == DATA)
      pkt_d = data_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q   <= 1'b0;
      is_data_q <= 1'b0;
      busy_q    <= 1'b0;
      pkt_q     <= '0;
      ack_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      is_data_q <= is_data_d;
      busy_q    <= busy_d;
      pkt_q     <= pkt_d;
      ack_q     <= ack_d;
    end
  end

  assign bus.o_tx_valid   = valid_q;
  assign bus.o_tx_is_data = is_data_q;
  assign bus.o_tx_packet  = pkt_q;
  assign bus.o_ack        = ack_q;
  assign bus.o_busy       = busy_q;
  assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_sb_tx_msg_arbiter.sv
// Scoreboard bench for sb_tx_msg_arbiter: directed messages with hand-computed
// header/data packets and ack pulses.
module tb_sb_tx_msg_arbiter;
  localparam int N_REQ = 4;

  // Hand-computed headers (opcode, MsgCode@[21:14], SubCode@[39:32], Info@[55:40], parity@63)
  localparam logic [63:0] H_85_01    = 64'h0000_0001_0021_4012;
  localparam logic [63:0] H_85_01_D  = 64'h0000_0001_0021_401B;
  localparam logic [63:0] H_A5_D     = 64'h0000_0000_0029_401B;
  localparam logic [63:0] H_A5       = 64'h0000_0000_0029_4012;
  localparam logic [63:0] H_01       = 64'h8000_0000_0000_4012;
  localparam logic [63:0] H_3C_BEEF  = 64'h80BE_EF5A_000F_0012;

  logic clk;
  logic rst_n;

  sb_tx_msg_arbiter_if #(.N_REQ(N_REQ)) bus ();

  sb_tx_msg_arbiter #(.N_REQ(N_REQ)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  logic [64:0]      exp_q[$];
  logic [N_REQ-1:0] exp_ack_q[$];
  int checks;
  int errors;
  int ack_seen;
  logic        prev_stall;
  logic [65:0] prev_pkt;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic set_fields(input int k, input logic [7:0] code, input logic [7:0] sub,
                            input logic [15:0] info, input logic hd, input logic [63:0] data);
    bus.i_msgcode[8*k +: 8]     = code;
    bus.i_msgsubcode[8*k +: 8]  = sub;
    bus.i_msginfo[16*k +: 16]   = info;
    bus.i_has_data[k]           = hd;
    bus.i_data[64*k +: 64]      = data;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acks(input int target, input int budget);
    int n;
    n = 0;
    while (ack_seen < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (ack_seen < target) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got %0d acks, required %0d", ack_seen, target);
    end
  endtask

  task automatic push_msg(input logic [63:0] hdr, input logic hd, input logic [63:0] data,
                          input logic [N_REQ-1:0] ack);
    exp_q.push_back({1'b0, hdr});
    if (hd) exp_q.push_back({1'b1, data});
    exp_ack_q.push_back(ack);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [65:0] cur;
    logic [64:0] e;
    logic [N_REQ-1:0] ea;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      cur = {bus.o_tx_valid, bus.o_tx_is_data, bus.o_tx_packet};
      if (prev_stall) check("hold_stable", cur, prev_pkt);
      if (bus.o_tx_valid && bus.i_tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_packet: got %h, required none", cur);
        end else begin
          e = exp_q.pop_front();
          check("packet", {1'b0, bus.o_tx_is_data, bus.o_tx_packet}, {1'b0, e});
        end
      end
      if (bus.o_ack != '0) begin
        ack_seen++;
        if (exp_ack_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got %b, required none", bus.o_ack);
        end else begin
          ea = exp_ack_q.pop_front();
          check("ack", 66'(bus.o_ack), 66'(ea));
        end
      end
      prev_stall = bus.o_tx_valid && !bus.i_tx_ready;
      prev_pkt   = cur;
    end
  end

  initial begin
    checks = 0; errors = 0; ack_seen = 0; prev_stall = 1'b0; prev_pkt = '0;
    rst_n = 1'b0;
    bus.i_req = '0; bus.i_msgcode = '0; bus.i_msgsubcode = '0; bus.i_msginfo = '0;
    bus.i_has_data = '0; bus.i_data = '0; bus.i_tx_ready = 1'b0;
    repeat (3) step();
    check("reset_pkt", {bus.o_tx_valid, bus.o_tx_is_data, bus.o_tx_packet}, '0);
    check("reset_ack_busy", 66'({bus.o_ack, bus.o_busy}), '0);
    rst_n = 1'b1;
    step();

    // single request, no data: header cycle 1, ack cycle 2
    set_fields(1, 8'h85, 8'h01, 16'h0000, 1'b0, '0);
    push_msg(H_85_01, 1'b0, '0, 4'b0010);
    bus.i_tx_ready = 1'b1;
    bus.i_req = 4'b0010;
    step();
    bus.i_req = '0;
    check("busy_c1", 66'(bus.o_busy), 66'(1));
    step();
    check("busy_c2", 66'(bus.o_busy), 66'(1));
    wait_acks(1, 20);
    check("busy_idle", 66'(bus.o_busy), 66'(0));

    // data message with backpressure: header 4 cycles, data 3 cycles
    set_fields(0, 8'hA5, 8'h00, 16'h0000, 1'b1, 64'h0000_0000_0000_07FF);
    push_msg(H_A5_D, 1'b1, 64'h0000_0000_0000_07FF, 4'b0001);
    bus.i_tx_ready = 1'b0;
    bus.i_req = 4'b0001;
    step();
    bus.i_req = '0;
    step();
    step();
    step();
    bus.i_tx_ready = 1'b1;
    step();
    bus.i_tx_ready = 1'b0;
    check("data_is_data", 66'({bus.o_tx_valid, bus.o_tx_is_data}), 66'(2'b11));
    step();
    step();
    bus.i_tx_ready = 1'b1;
    wait_acks(2, 20);

    // pointer wrap: grant 3, then 4'b1001 grants 0, then 3 again
    set_fields(3, 8'h01, 8'h00, 16'h0000, 1'b0, '0);
    set_fields(0, 8'hA5, 8'h00, 16'h0000, 1'b0, '0);
    push_msg(H_01, 1'b0, '0, 4'b1000);
    bus.i_req = 4'b1000;
    wait_acks(3, 20);
    push_msg(H_A5, 1'b0, '0, 4'b0001);
    bus.i_req = 4'b1001;
    wait_acks(4, 20);
    push_msg(H_01, 1'b0, '0, 4'b1000);
    bus.i_req = 4'b1000;
    wait_acks(5, 20);

    // round robin with all requesting continuously: 0,1,2,3,0
    set_fields(2, 8'h3C, 8'h5A, 16'hBEEF, 1'b0, '0);
    push_msg(H_A5, 1'b0, '0, 4'b0001);
    push_msg(H_85_01, 1'b0, '0, 4'b0010);
    push_msg(H_3C_BEEF, 1'b0, '0, 4'b0100);
    push_msg(H_01, 1'b0, '0, 4'b1000);
    push_msg(H_A5, 1'b0, '0, 4'b0001);
    bus.i_req = 4'b1111;
    wait_acks(10, 60);
    bus.i_req = '0;

    // withdrawal and field change after the latch edge
    push_msg(H_3C_BEEF, 1'b0, '0, 4'b0100);
    bus.i_req = 4'b0100;
    step();
    bus.i_req = '0;
    set_fields(2, 8'hFF, 8'hFF, 16'hFFFF, 1'b1, '1);
    wait_acks(11, 20);

    // reset during DATA drops the message without ack and resets rr_ptr
    set_fields(1, 8'h85, 8'h01, 16'h0000, 1'b1, 64'hDEAD_BEEF_0123_4567);
    exp_q.push_back({1'b0, H_85_01_D});
    bus.i_req = 4'b0010;
    step();
    bus.i_req = '0;
    step();
    bus.i_tx_ready = 1'b0;
    check("pre_reset_data", 66'({bus.o_tx_valid, bus.o_tx_is_data}), 66'(2'b11));
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_pkt", {bus.o_tx_valid, bus.o_tx_is_data, bus.o_tx_packet}, '0);
    check("midreset_ack_busy", 66'({bus.o_ack, bus.o_busy}), '0);
    step();
    step();
    rst_n = 1'b1;
    step();
    set_fields(2, 8'h85, 8'h01, 16'h0000, 1'b0, '0);
    push_msg(H_85_01, 1'b0, '0, 4'b0100);
    push_msg(H_01, 1'b0, '0, 4'b1000);
    bus.i_tx_ready = 1'b1;
    bus.i_req = 4'b1100;
    wait_acks(13, 30);
    bus.i_req = '0;

    repeat (5) step();
    check("exp_q_empty", 66'(exp_q.size()), '0);
    check("exp_ack_q_empty", 66'(exp_ack_q.size()), '0);
    check("final_idle", 66'({bus.o_busy, bus.o_tx_valid}), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
